pipe_stage_reg: RTL and testbench

Generic, parametrised inter-stage pipeline register for the five-stage CPU. It replaces the fixed-field per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle under a valid/ready handshake, with synchronous flush and bubble insertion. An optional two-entry skid mode breaks the combinational ready path between stages. Bubbles always present all-zero control, so a stalled or flushed slot can never assert register or memory writes downstream.

---
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: control + data bundles under valid/ready,
// synchronous flush, optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64,
    parameter int SKID   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic       SKID_EN  = (SKID != 0);

    logic [1:0]        state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic              rdy_q, rdy_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Upstream ready: a flop in skid mode, otherwise a pass-through of out_ready.
    always_comb begin
        if (SKID_EN) begin
            in_ready_s = rdy_q;
        end else begin
            in_ready_s = out_ready_i | ~m_valid_q;
        end
    end

    assign in_fire_s  = in_valid_i & in_ready_s;
    assign out_fire_s = m_valid_q & out_ready_i;

    // Next-state and storage steering; flush overrides every transition.
    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = in_ctrl_i;
                        m_data_d = in_data_i;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    // Without a skid entry an accept always coincides with a drain.
                    if (in_fire_s && (out_fire_s || !SKID_EN)) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = in_ctrl_i;
                        m_data_d = in_data_i;
                    end else if (in_fire_s) begin
                        state_d  = ST_FULL;
                        s_ctrl_d = in_ctrl_i;
                        s_data_d = in_data_i;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        state_d  = ST_ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        m_valid_d = (state_d != ST_EMPTY);
        rdy_d     = (state_d != ST_FULL);
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            m_valid_q <= 1'b0;
            rdy_q     <= 1'b1;
            m_ctrl_q  <= {CTRL_W{1'b0}};
            m_data_q  <= {DATA_W{1'b0}};
            s_ctrl_q  <= {CTRL_W{1'b0}};
            s_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            rdy_q     <= rdy_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end

    // Bubbles never present live control downstream.
    assign in_ready_o  = in_ready_s;
    assign out_valid_o = m_valid_q;
    assign out_ctrl_o  = m_valid_q ? m_ctrl_q : {CTRL_W{1'b0}};
    assign out_data_o  = m_data_q;
    assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 is SKID=0, instance 1 is SKID=1; directed
// vector tables, hand sequences for async reset / ready paths, random FIFO-model run.
module tb_pipe_stage_reg;

    localparam int CW = 8;
    localparam int DW = 64;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ov;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        logic [1:0]    occ;
        logic          irdy;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fl  [2];
    logic          iv  [2];
    logic          ir  [2];
    logic [CW-1:0] ic  [2];
    logic [DW-1:0] id  [2];
    logic          ov  [2];
    logic          orr [2];
    logic [CW-1:0] oc  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    occ [2];

    int n_tests = 0;
    int n_fail  = 0;
    vec_t t0 [10];
    vec_t t1 [16];
    logic [CW+DW-1:0] mq [$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .flush_i(fl[0]), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .in_ctrl_i(ic[0]), .in_data_i(id[0]), .out_valid_o(ov[0]), .out_ready_i(orr[0]),
        .out_ctrl_o(oc[0]), .out_data_o(od[0]), .occupancy_o(occ[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_s1 (
        .clk(clk), .rst(rst), .flush_i(fl[1]), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .in_ctrl_i(ic[1]), .in_data_i(id[1]), .out_valid_o(ov[1]), .out_ready_i(orr[1]),
        .out_ctrl_o(oc[1]), .out_data_o(od[1]), .occupancy_o(occ[1])
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic f, input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input logic r);
        @(negedge clk);
        fl[k]  = f;
        iv[k]  = v;
        ic[k]  = c;
        id[k]  = d;
        orr[k] = r;
    endtask

    task automatic check_all(input int k, input string tag, input logic v, input logic [CW-1:0] c,
                             input logic [DW-1:0] d, input logic [1:0] o, input logic r);
        check($sformatf("s%0d %s out_valid", k, tag), DW'(ov[k]), DW'(v));
        check($sformatf("s%0d %s out_ctrl", k, tag), DW'(oc[k]), DW'(c));
        check($sformatf("s%0d %s out_data", k, tag), od[k], d);
        check($sformatf("s%0d %s occupancy", k, tag), DW'(occ[k]), DW'(o));
        check($sformatf("s%0d %s in_ready", k, tag), DW'(ir[k]), DW'(r));
    endtask

    task automatic run_vec(input int k, input vec_t v, input int idx);
        drive(k, v.fl, v.iv, v.ic, v.id, v.ordy);
        @(posedge clk);
        #1;
        check_all(k, $sformatf("v%0d", idx), v.ov, v.oc, v.od, v.occ, v.irdy);
    endtask

    // Reference FIFO model against random valid/ready/flush traffic.
    task automatic rand_run(input int k, input int n);
        logic exp_ir;
        logic do_in;
        logic do_out;
        drive(k, 1'b1, 1'b0, {CW{1'b0}}, {DW{1'b0}}, 1'b0);
        @(posedge clk);
        mq.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fl[k]  = ($urandom_range(0, 15) == 0);
            iv[k]  = 1'($urandom_range(0, 1));
            ic[k]  = CW'($urandom);
            id[k]  = {$urandom, $urandom};
            orr[k] = 1'($urandom_range(0, 1));
            #1;
            exp_ir = (k == 0) ? (orr[k] | (mq.size() == 0)) : (mq.size() < 2);
            check($sformatf("s%0d rnd%0d in_ready", k, c), DW'(ir[k]), DW'(exp_ir));
            check($sformatf("s%0d rnd%0d out_valid", k, c), DW'(ov[k]), DW'(mq.size() != 0));
            if (mq.size() != 0) begin
                check($sformatf("s%0d rnd%0d out_ctrl", k, c), DW'(oc[k]), DW'(mq[0][CW+DW-1:DW]));
                check($sformatf("s%0d rnd%0d out_data", k, c), od[k], mq[0][DW-1:0]);
            end else begin
                check($sformatf("s%0d rnd%0d bubble ctrl", k, c), DW'(oc[k]), {DW{1'b0}});
            end
            do_out = (mq.size() != 0) && orr[k];
            do_in  = iv[k] && exp_ir;
            @(posedge clk);
            if (fl[k]) begin
                mq.delete();
            end else begin
                if (do_out) void'(mq.pop_front());
                if (do_in) mq.push_back({ic[k], id[k]});
            end
            #1;
            check($sformatf("s%0d rnd%0d occupancy", k, c), DW'(occ[k]), DW'(mq.size()));
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fl[k]  = 1'b1;
            iv[k]  = 1'b1;
            ic[k]  = {CW{1'b1}};
            id[k]  = {DW{1'bx}};
            orr[k] = 1'b1;
        end

        // fl, iv, ic, id, out_ready | out_valid, out_ctrl, out_data, occupancy, in_ready
        t0[0] = '{1'b0, 1'b1, 8'h81, 64'h1111_2222, 1'b1, 1'b1, 8'h81, 64'h1111_2222, 2'd1, 1'b1};
        t0[1] = '{1'b0, 1'b1, 8'h42, 64'h3333_4444, 1'b1, 1'b1, 8'h42, 64'h3333_4444, 2'd1, 1'b1};
        t0[2] = '{1'b0, 1'b0, 8'hEE, 64'hDEAD_0001, 1'b1, 1'b0, 8'h00, 64'h3333_4444, 2'd0, 1'b1};
        t0[3] = '{1'b0, 1'b0, 8'hEE, 64'hDEAD_0002, 1'b1, 1'b0, 8'h00, 64'h3333_4444, 2'd0, 1'b1};
        t0[4] = '{1'b0, 1'b0, 8'hEE, 64'hDEAD_0003, 1'b1, 1'b0, 8'h00, 64'h3333_4444, 2'd0, 1'b1};
        t0[5] = '{1'b0, 1'b1, 8'h5A, 64'h0000_0055, 1'b0, 1'b1, 8'h5A, 64'h0000_0055, 2'd1, 1'b0};
        t0[6] = '{1'b0, 1'b1, 8'h66, 64'h0000_0066, 1'b0, 1'b1, 8'h5A, 64'h0000_0055, 2'd1, 1'b0};
        t0[7] = '{1'b0, 1'b1, 8'h66, 64'h0000_0066, 1'b1, 1'b1, 8'h66, 64'h0000_0066, 2'd1, 1'b1};
        t0[8] = '{1'b1, 1'b1, 8'h77, 64'h0000_0077, 1'b1, 1'b0, 8'h00, 64'h0000_0066, 2'd0, 1'b1};
        t0[9] = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b0, 1'b0, 8'h00, 64'h0000_0066, 2'd0, 1'b1};

        t1[0]  = '{1'b0, 1'b1, 8'h81, 64'hAAAA_0001, 1'b0, 1'b1, 8'h81, 64'hAAAA_0001, 2'd1, 1'b1};
        t1[1]  = '{1'b0, 1'b1, 8'h42, 64'hBBBB_0002, 1'b0, 1'b1, 8'h81, 64'hAAAA_0001, 2'd2, 1'b0};
        t1[2]  = '{1'b0, 1'b1, 8'h13, 64'hCCCC_0003, 1'b0, 1'b1, 8'h81, 64'hAAAA_0001, 2'd2, 1'b0};
        t1[3]  = '{1'b0, 1'b1, 8'h13, 64'hCCCC_0003, 1'b1, 1'b1, 8'h42, 64'hBBBB_0002, 2'd1, 1'b1};
        t1[4]  = '{1'b0, 1'b1, 8'h13, 64'hCCCC_0003, 1'b1, 1'b1, 8'h13, 64'hCCCC_0003, 2'd1, 1'b1};
        t1[5]  = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b1, 1'b0, 8'h00, 64'hCCCC_0003, 2'd0, 1'b1};
        t1[6]  = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b1, 1'b0, 8'h00, 64'hCCCC_0003, 2'd0, 1'b1};
        t1[7]  = '{1'b0, 1'b1, 8'h7F, 64'hDDDD_0004, 1'b1, 1'b1, 8'h7F, 64'hDDDD_0004, 2'd1, 1'b1};
        t1[8]  = '{1'b0, 1'b1, 8'h01, 64'hEEEE_0005, 1'b0, 1'b1, 8'h7F, 64'hDDDD_0004, 2'd2, 1'b0};
        t1[9]  = '{1'b1, 1'b1, 8'h55, 64'hFFFF_0006, 1'b0, 1'b0, 8'h00, 64'hDDDD_0004, 2'd0, 1'b1};
        t1[10] = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b1, 1'b0, 8'h00, 64'hDDDD_0004, 2'd0, 1'b1};
        t1[11] = '{1'b0, 1'b1, 8'h24, 64'h0000_1234, 1'b1, 1'b1, 8'h24, 64'h0000_1234, 2'd1, 1'b1};
        t1[12] = '{1'b1, 1'b1, 8'h99, 64'h0000_9999, 1'b1, 1'b0, 8'h00, 64'h0000_1234, 2'd0, 1'b1};
        t1[13] = '{1'b0, 1'b1, 8'hFF, {64{1'b1}},    1'b0, 1'b1, 8'hFF, {64{1'b1}},    2'd1, 1'b1};
        t1[14] = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b0, 1'b1, 8'hFF, {64{1'b1}},    2'd1, 1'b1};
        t1[15] = '{1'b0, 1'b0, 8'h00, 64'h0000_0000, 1'b1, 1'b0, 8'h00, {64{1'b1}},    2'd0, 1'b1};

        // Reset takes effect with no clock edge in between.
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_all(k, "reset", 1'b0, 8'h00, 64'h0, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fl[k] = 1'b0; iv[k] = 1'b0; ic[k] = 8'h00; id[k] = 64'h0; orr[k] = 1'b1;
        end

        for (int i = 0; i < 10; i++) run_vec(0, t0[i], i);
        for (int i = 0; i < 16; i++) run_vec(1, t1[i], i);

        // Ready-path sequence: SKID=0 follows out_ready at once, SKID=1 does not.
        drive(0, 1'b0, 1'b1, 8'hC3, 64'h0000_00C3, 1'b0);
        drive(1, 1'b0, 1'b1, 8'hA1, 64'h0000_00A1, 1'b0);
        drive(1, 1'b0, 1'b1, 8'hB2, 64'h0000_00B2, 1'b0);
        @(posedge clk);
        #1;
        check("s1 full occupancy", DW'(occ[1]), 64'd2);
        check("s1 full in_ready", DW'(ir[1]), 64'd0);
        check("s0 stalled in_ready", DW'(ir[0]), 64'd0);
        iv[0] = 1'b0; orr[0] = 1'b1;
        iv[1] = 1'b0; orr[1] = 1'b1;
        #1;
        check("s0 comb in_ready", DW'(ir[0]), 64'd1);
        check("s1 no comb in_ready", DW'(ir[1]), 64'd0);

        // Asynchronous reset while the skid instance is FULL.
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) check_all(k, "mid rst", 1'b0, 8'h00, 64'h0, 2'd0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1'b0, 1'b1, 8'hD4, 64'h0000_00D4, 1'b0);
        @(posedge clk);
        #1;
        check_all(1, "post rst", 1'b1, 8'hD4, 64'h0000_00D4, 2'd1, 1'b1);

        rand_run(0, 300);
        rand_run(1, 300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
